// File: rtl/wb_load_align_if.sv
// wb_load_align_if: MEM-to-WB capture, dcache response and register-file write bundle
// master: drives mem_*, flush, dresp_*; receives we/waddr/wdata/wdata_raw, wb_stallreq, mem_ready
// slave:  the writeback stage (wb_load_align)
// WB_TRACE_EN adds debug_wb_pc/rf_wen/rf_wnum/rf_wdata, driven by the slave
interface wb_load_align_if;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [3:0]  mem_wen;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic        mem_req_issued;
    logic        flush;
    logic        dresp_valid;
    logic [31:0] dresp_data;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] wdata_raw;
    logic        wb_stallreq;
    logic        mem_ready;
`ifdef WB_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif
    modport master (
        output mem_valid, mem_pc, mem_wen, mem_waddr, mem_wdata, mem_is_load, mem_load_type,
               mem_addr_lo, mem_req_issued, flush, dresp_valid, dresp_data,
        input  we, waddr, wdata, wdata_raw, wb_stallreq, mem_ready
`ifdef WB_TRACE_EN
        , input debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
    );
    modport slave (
        input  mem_valid, mem_pc, mem_wen, mem_waddr, mem_wdata, mem_is_load, mem_load_type,
               mem_addr_lo, mem_req_issued, flush, dresp_valid, dresp_data,
        output we, waddr, wdata, wdata_raw, wb_stallreq, mem_ready
`ifdef WB_TRACE_EN
        , output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
    );
endinterface

// File: rtl/wb_load_align.sv
// wb_load_align: writeback register that waits for load data, aligns/extends/lane-merges it and drives the RF write port
// clk, rst_n (async active-low); bus (wb_load_align_if.slave): MEM capture inputs, flush,
// dcache response, RF write outputs we/waddr/wdata/wdata_raw, wb_stallreq and mem_ready
// WB_TRACE_EN: adds debug_wb_* trace outputs and the PC register
module wb_load_align #(
    parameter int          DROP_W   = 2,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input logic clk,
    input logic rst_n,
    wb_load_align_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state;
    logic        valid, is_load;
    logic [2:0]  ltype;
    logic [1:0]  a;
    logic [3:0]  wen;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [DROP_W-1:0] drop;
    logic        usable, stall, wr, cap, inc, dec;
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  ld_we, we;
    logic [31:0] ld_data, wd;
    always_comb begin
        usable  = bus.dresp_valid && drop == '0;
        stall   = state == WAIT && !usable;
        wr      = state == WAIT ? usable : valid && !is_load;
        b       = bus.dresp_data[{a, 3'b000} +: 8];
        h       = a[1] ? bus.dresp_data[31:16] : bus.dresp_data[15:0];
        ld_we   = ltype == 3'd5 ? 4'hF << (2'd3 - a) : ltype == 3'd6 ? 4'hF >> a : 4'hF;
        ld_data = ltype == 3'd0 ? {{24{b[7]}}, b} :
                  ltype == 3'd1 ? {24'h0, b} :
                  ltype == 3'd2 ? {{16{h[15]}}, h} :
                  ltype == 3'd3 ? {16'h0, h} :
                  ltype == 3'd5 ? bus.dresp_data << {2'd3 - a, 3'b000} :
                  ltype == 3'd6 ? bus.dresp_data >> {a, 3'b000} : bus.dresp_data;
        we      = wr && rd != 5'd0 ? (is_load ? ld_we : wen) : 4'h0;
        // masking by lane enables zeroes disabled lanes and clears wdata when nothing is written
        wd      = (is_load ? ld_data : res) & {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        cap     = bus.mem_valid && !bus.flush;
        // a killed load whose request already left will still get a response that must be discarded
        inc     = bus.flush && bus.mem_valid && bus.mem_is_load && bus.mem_req_issued;
        dec     = bus.dresp_valid && drop != '0;
    end
    assign bus.we          = we;
    assign bus.waddr       = |we ? rd : 5'd0;
    assign bus.wdata       = wd;
    assign bus.wdata_raw   = wd;
    assign bus.wb_stallreq = stall;
    assign bus.mem_ready   = !stall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid   <= 1'b0;
            is_load <= 1'b0;
            ltype   <= 3'd0;
            a       <= 2'd0;
            wen     <= 4'h0;
            rd      <= 5'd0;
            res     <= 32'h0;
            drop    <= '0;
        end else begin
            if (inc && !dec && !(&drop))
                drop <= drop + 1'b1;
            else if (dec && !inc)
                drop <= drop - 1'b1;
            if (!stall) begin
                valid   <= cap;
                is_load <= bus.mem_is_load;
                ltype   <= bus.mem_load_type;
                a       <= bus.mem_addr_lo;
                wen     <= bus.mem_wen;
                rd      <= bus.mem_waddr;
                res     <= bus.mem_wdata;
                state   <= cap && bus.mem_is_load ? WAIT : IDLE;
            end
        end
    end
`ifdef WB_TRACE_EN
    logic [31:0] pc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (!stall)
            pc <= bus.mem_pc;
    end
    assign bus.debug_wb_pc       = pc;
    assign bus.debug_wb_rf_wen   = we;
    assign bus.debug_wb_rf_wnum  = bus.waddr;
    assign bus.debug_wb_rf_wdata = wd;
`else
    logic unused_trace;
    assign unused_trace = ^{bus.mem_pc, RESET_PC};
`endif
endmodule

// File: tb/tb_wb_load_align.sv
// tb_wb_load_align: scoreboard bench; stimulus pushes expected RF writes, a negedge monitor pops and compares
module tb_wb_load_align;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    typedef struct {
        logic [3:0]  we;
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;
    typedef struct {
        logic [2:0]  t;
        logic [1:0]  a;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [3:0]  we;
        logic [31:0] exp;
    } vec_t;
    wr_t q[$];
    vec_t vecs[11];
    wb_load_align_if bus();
    wb_load_align #(.DROP_W(2), .RESET_PC(32'hBFC0_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_mem(input logic v, input logic ld, input logic [2:0] t, input logic [1:0] a,
                           input logic [4:0] rd, input logic [3:0] wen, input logic [31:0] d,
                           input logic req, input logic fl);
        bus.mem_valid      = v;
        bus.mem_is_load    = ld;
        bus.mem_load_type  = t;
        bus.mem_addr_lo    = a;
        bus.mem_waddr      = rd;
        bus.mem_wen        = wen;
        bus.mem_wdata      = d;
        bus.mem_req_issued = req;
        bus.flush          = fl;
        bus.mem_pc         = 32'hBFC0_0100;
    endtask
    task automatic idle_mem();
        set_mem(1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask
    task automatic resp(input logic v, input logic [31:0] d);
        bus.dresp_valid = v;
        bus.dresp_data  = d;
    endtask
    task automatic expect_wr(input logic [3:0] we, input logic [4:0] rd, input logic [31:0] d);
        wr_t w;
        w.we = we;
        w.rd = rd;
        w.d  = d;
        q.push_back(w);
    endtask
    task automatic chk_stall(input logic exp);
        @(negedge clk);
        chk("wb_stallreq", {31'h0, bus.wb_stallreq}, {31'h0, exp});
        chk("mem_ready", {31'h0, bus.mem_ready}, {31'h0, !exp});
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            wr_t w;
            w = q.pop_front();
            chk("we", {28'h0, bus.we}, {28'h0, w.we});
            chk("waddr", {27'h0, bus.waddr}, {27'h0, w.rd});
            chk("wdata", bus.wdata, w.d);
            chk("wdata_raw", bus.wdata_raw, w.d);
        end else if (bus.we !== 4'h0) begin
            total++;
            $display("FAIL unexpected_write: we=%h waddr=%0d wdata=%h expected no write at %0t",
                     bus.we, bus.waddr, bus.wdata, $time);
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        vecs[0]  = '{3'd0, 2'd2, 5'd4,  32'h0080_0000, 4'hF, 32'hFFFF_FF80};
        vecs[1]  = '{3'd1, 2'd2, 5'd4,  32'h0080_0000, 4'hF, 32'h0000_0080};
        vecs[2]  = '{3'd2, 2'd2, 5'd11, 32'h8001_7FFF, 4'hF, 32'hFFFF_8001};
        vecs[3]  = '{3'd3, 2'd0, 5'd11, 32'h8001_7FFF, 4'hF, 32'h0000_7FFF};
        vecs[4]  = '{3'd5, 2'd3, 5'd12, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD};
        vecs[5]  = '{3'd5, 2'd0, 5'd12, 32'hAABB_CCDD, 4'h8, 32'hDD00_0000};
        vecs[6]  = '{3'd5, 2'd2, 5'd12, 32'hAABB_CCDD, 4'hE, 32'hBBCC_DD00};
        vecs[7]  = '{3'd6, 2'd3, 5'd13, 32'hAABB_CCDD, 4'h1, 32'h0000_00AA};
        vecs[8]  = '{3'd6, 2'd2, 5'd13, 32'hAABB_CCDD, 4'h3, 32'h0000_AABB};
        vecs[9]  = '{3'd7, 2'd1, 5'd14, 32'h1234_5678, 4'hF, 32'h1234_5678};
        vecs[10] = '{3'd0, 2'd3, 5'd14, 32'hAABB_CCDD, 4'hF, 32'hFFFF_FFAA};
        idle_mem();
        resp(1'b0, 32'h0);
        #12;
        chk("rst_we", {28'h0, bus.we}, 32'h0);
        chk("rst_waddr", {27'h0, bus.waddr}, 32'h0);
        chk("rst_wdata", bus.wdata, 32'h0);
        chk("rst_wdata_raw", bus.wdata_raw, 32'h0);
        chk("rst_stall", {31'h0, bus.wb_stallreq}, 32'h0);
        tick();
        rst_n = 1'b1;
        // ADDU $3
        set_mem(1'b1, 1'b0, 3'd0, 2'd0, 5'd3, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
        tick();
        idle_mem();
        expect_wr(4'hF, 5'd3, 32'h1234_5678);
        chk_stall(1'b0);
        tick();
        // back-to-back loads, each answered in its first WB cycle
        set_mem(1'b1, 1'b1, vecs[0].t, vecs[0].a, vecs[0].rd, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 11; i++) begin
            resp(1'b1, vecs[i].d);
            if (i < 10) set_mem(1'b1, 1'b1, vecs[i+1].t, vecs[i+1].a, vecs[i+1].rd, 4'h0, 32'h0, 1'b1, 1'b0);
            else idle_mem();
            expect_wr(vecs[i].we, vecs[i].rd, vecs[i].exp);
            chk_stall(1'b0);
            tick();
        end
        resp(1'b0, 32'h0);
        // LWL $5 a=1, response three cycles late
        set_mem(1'b1, 1'b1, 3'd5, 2'd1, 5'd5, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        idle_mem();
        for (int i = 0; i < 3; i++) begin
            chk_stall(1'b1);
            tick();
        end
        resp(1'b1, 32'hAABB_CCDD);
        expect_wr(4'hC, 5'd5, 32'hCCDD_0000);
        chk_stall(1'b0);
        tick();
        resp(1'b0, 32'h0);
        // LWR $5 a=1, immediate response
        set_mem(1'b1, 1'b1, 3'd6, 2'd1, 5'd5, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        idle_mem();
        resp(1'b1, 32'hAABB_CCDD);
        expect_wr(4'h7, 5'd5, 32'h00AA_BBCC);
        chk_stall(1'b0);
        tick();
        resp(1'b0, 32'h0);
        // stale response from a flushed load is discarded while LW $6 waits
        set_mem(1'b1, 1'b1, 3'd4, 2'd0, 5'd6, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        set_mem(1'b1, 1'b1, 3'd4, 2'd0, 5'd7, 4'h0, 32'h0, 1'b1, 1'b1);
        chk_stall(1'b1);
        tick();
        idle_mem();
        resp(1'b1, 32'h1111_1111);
        chk_stall(1'b1);
        tick();
        resp(1'b1, 32'h2222_2222);
        expect_wr(4'hF, 5'd6, 32'h2222_2222);
        chk_stall(1'b0);
        tick();
        resp(1'b0, 32'h0);
        chk_stall(1'b0);
        tick();
        // load to $0: no write, returns to IDLE
        set_mem(1'b1, 1'b1, 3'd4, 2'd0, 5'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        idle_mem();
        resp(1'b1, 32'hDEAD_BEEF);
        chk_stall(1'b0);
        tick();
        resp(1'b0, 32'h0);
        chk_stall(1'b0);
        tick();
        // reset during WAIT with a pending drop count
        set_mem(1'b1, 1'b1, 3'd4, 2'd0, 5'd8, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        set_mem(1'b1, 1'b1, 3'd4, 2'd0, 5'd9, 4'h0, 32'h0, 1'b1, 1'b1);
        chk_stall(1'b1);
        tick();
        idle_mem();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", {28'h0, bus.we}, 32'h0);
        chk("async_rst_waddr", {27'h0, bus.waddr}, 32'h0);
        chk("async_rst_wdata", bus.wdata, 32'h0);
        chk("async_rst_stall", {31'h0, bus.wb_stallreq}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        set_mem(1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b0);
        tick();
        set_mem(1'b1, 1'b1, 3'd4, 2'd0, 5'd10, 4'h0, 32'h0, 1'b1, 1'b0);
        expect_wr(4'hF, 5'd9, 32'h0BAD_F00D);
        chk_stall(1'b0);
        tick();
        idle_mem();
        resp(1'b1, 32'hCAFE_F00D);
        expect_wr(4'hF, 5'd10, 32'hCAFE_F00D);
        chk_stall(1'b0);
        tick();
        resp(1'b0, 32'h0);
        @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_load_align.md
Name: wb_load_align

Overview:
- Writeback stage register sitting directly upstream of the register file.
- Captures the retiring MEM-stage instruction and waits for the data-cache load response.
- Aligns, sign/zero-extends and lane-merges load data (LB/LBU/LH/LHU/LW/LWL/LWR).
- Drives the register file's per-byte write port (we/waddr/wdata/wdata_raw); stalls the pipeline while a load response is outstanding.

Parameters:
DROP_W, 2, width of the saturating counter of stale (flushed) load responses to discard
RESET_PC, 32'hBFC0_0000, reset value of the internal PC register (trace only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_valid  in  1  MEM presents a valid instruction
mem_pc  in  32  PC of MEM instruction
mem_wen  in  4  byte write enables for non-load results (4'hF or 4'h0)
mem_waddr  in  5  destination GPR
mem_wdata  in  32  non-load result
mem_is_load  in  1  instruction is a load
mem_load_type  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 treated as LW
mem_addr_lo  in  2  load address bits [1:0]
mem_req_issued  in  1  MEM instruction has already sent its dcache request
flush  in  1  kill the MEM instruction (exception/eret)
dresp_valid  in  1  load response valid, single-cycle pulse
dresp_data  in  32  load response word
we  out  4  byte write enables to register file
waddr  out  5  write address
wdata  out  32  lane-positioned write data
wdata_raw  out  32  bypass copy of write data, same cycle
wb_stallreq  out  1  WB cannot accept a new instruction
mem_ready  out  1  equals ~wb_stallreq

Behaviour:
- Reset (async, rst_n=0): valid=0, state IDLE, drop count 0; outputs we=0, waddr=0, wdata=0, wdata_raw=0, wb_stallreq=0.
- Capture:
  - On clk when mem_ready=1: WB register loads mem_* if mem_valid & ~flush; otherwise it loads a bubble.
  - When wb_stallreq=1: register holds.
- Non-load in WB: we=mem_wen as captured, wdata=captured result, in the cycle it sits in WB; state stays IDLE.
- States:
  - IDLE: no load waiting.
  - WAIT: valid load in WB without data.
- Transitions:
  - IDLE→WAIT: on capture of a load.
  - WAIT→IDLE: on dresp_valid with drop count 0; the write occurs combinationally in that same cycle and wb_stallreq=0 that cycle.
  - WAIT→WAIT: on capture of a back-to-back load in the response cycle.
- wb_stallreq=1 iff state WAIT and the current cycle lacks a usable response.
  - A load whose response arrives in its first WB cycle causes no stall.
- Drop counter:
  - Increments (saturating at 2^DROP_W-1) when flush=1 & mem_valid & mem_is_load & mem_req_issued at a clock edge.
  - While the count is nonzero, each dresp_valid is consumed by the counter (decrement), never written, and does not end WAIT.
  - Simultaneous increment and decrement leave the count unchanged.
- flush never kills the instruction already in WB; a WAIT in progress continues.
- Alignment, with a=addr_lo and D=dresp_data:
  - LB/LBU: D[8a+7:8a], sign/zero-extended, we=1111.
  - LH/LHU: D[16a1+15:16a1], sign/zero-extended, we=1111. a[0] is guaranteed 0 upstream.
  - LW: D, we=1111.
  - LWL:
    - a=0: we=1000, wdata[31:24]=D[7:0]
    - a=1: we=1100, [31:16]=D[15:0]
    - a=2: we=1110, [31:8]=D[23:0]
    - a=3: we=1111, D
  - LWR:
    - a=0: we=1111, D
    - a=1: we=0111, [23:0]=D[31:8]
    - a=2: we=0011, [15:0]=D[31:16]
    - a=3: we=0001, [7:0]=D[31:24]
  - Disabled lanes of wdata are 0.
- waddr==0 forces we=0.
- When we=0, waddr and wdata are 0.
- wdata_raw==wdata always.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: adds outputs debug_wb_pc[31:0], debug_wb_rf_wen[3:0], debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0]. These mirror pc/we/waddr/wdata in the write cycle; debug_wb_rf_wen=0 otherwise; reset pc=RESET_PC.
- Undefined: ports and PC register absent; no other behaviour change.

Test Plan:
- ADDU to $3 result 32'h1234_5678, no load → next cycle we=1111, waddr=3, wdata=32'h1234_5678, wb_stallreq=0.
- LB $4, a=2, D=32'h0080_0000, dresp in first WB cycle → same cycle we=1111, wdata=32'hFFFF_FF80, no stall; LBU same → 32'h0000_0080.
- LWL $5, a=1, D=32'hAABB_CCDD, dresp 3 cycles late → wb_stallreq=1 for 3 cycles, then we=1100, wdata=32'hCCDD_0000 one cycle; LWR a=1 same D → we=0111, wdata=32'h00AA_BBCC.
- Load in MEM with mem_req_issued=1 and flush=1 while a WB load waits → first dresp discarded (count 1→0, no write), second dresp completes WB load.
- Load with waddr=0 and dresp arriving → we=0, state returns IDLE, no stall after.
- rst_n asserted during WAIT → all outputs 0 immediately, state IDLE, drop count 0; after release, ADDU captured normally.
